// File: rtl/pause_pkg.sv
// Shared definitions for the pause controller: FSM encodings, option bit
// positions and the dim-level width helper.
package pause_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_PEND   = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_STEP   = 2'd3;

    localparam int OPT_OSD   = 0;
    localparam int OPT_DIM   = 1;
    localparam int OPT_ALIGN = 2;

    // Bits needed to hold a shift amount of 0..max_dim.
    function automatic int dim_width(input int max_dim);
        return (max_dim < 1) ? 1 : $clog2(max_dim + 1);
    endfunction

endpackage

// File: rtl/pause_ctrl_if.sv
// Video-side bundle between the core and the pause controller: raw RGB and
// vblank in, dimmed RGB out.
interface pause_ctrl_if #(
    parameter int RW = 8,
    parameter int GW = 8,
    parameter int BW = 8
);
    logic [RW-1:0]       r;
    logic [GW-1:0]       g;
    logic [BW-1:0]       b;
    logic                vblank;
    logic [RW+GW+BW-1:0] rgb_out;

    modport master (output r, g, b, vblank, input rgb_out);
    modport slave  (input r, g, b, vblank, output rgb_out);
endinterface

// File: rtl/pause_dimmer.sv
// Timed multi-level video dim: waits DIM_CYCLES of active time, then deepens
// the right-shift every FADE_CYCLES until MAX_DIM.
module pause_dimmer
    import pause_pkg::*;
#(
    parameter int RW          = 8,
    parameter int GW          = 8,
    parameter int BW          = 8,
    parameter int DIM_CYCLES  = 120_000_000,
    parameter int FADE_CYCLES = 12_000_000,
    parameter int MAX_DIM     = 3,
    parameter int DLW         = dim_width(MAX_DIM)
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                active,
    input  logic [RW-1:0]       r,
    input  logic [GW-1:0]       g,
    input  logic [BW-1:0]       b,
    output logic [DLW-1:0]      dim_level,
    output logic [RW+GW+BW-1:0] rgb_out
);

    localparam int TMAX = (DIM_CYCLES > FADE_CYCLES) ? DIM_CYCLES : FADE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    logic [TW-1:0]  timer_q, timer_d;
    logic [DLW-1:0] level_q, level_d;

    // Timer restarts on every level step and freezes once the level saturates.
    always_comb begin
        timer_d = timer_q;
        level_d = level_q;
        if (!active) begin
            timer_d = '0;
            level_d = '0;
        end else if (level_q == '0) begin
            if (timer_q == TW'(DIM_CYCLES - 1)) begin
                timer_d = '0;
                level_d = DLW'(1);
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end else if (level_q < DLW'(MAX_DIM)) begin
            if (timer_q == TW'(FADE_CYCLES - 1)) begin
                timer_d = '0;
                level_d = level_q + DLW'(1);
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
            level_q <= '0;
        end else begin
            timer_q <= timer_d;
            level_q <= level_d;
        end
    end

    assign dim_level = level_q;
    assign rgb_out   = {r >> level_q, g >> level_q, b >> level_q};

endmodule

// File: rtl/pause_ctrl.sv
// Pause controller: merges pause sources, optionally aligns entry to vblank,
// supports single-frame stepping and dims the picture while paused.
module pause_ctrl
    import pause_pkg::*;
#(
    parameter int RW          = 8,
    parameter int GW          = 8,
    parameter int BW          = 8,
    parameter int CLKSPD      = 12,
    parameter int NREQ        = 4,
    parameter int DIM_CYCLES  = CLKSPD * 10_000_000,
    parameter int FADE_CYCLES = CLKSPD * 1_000_000,
    parameter int MAX_DIM     = 3,
    parameter int DLW         = dim_width(MAX_DIM)
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            cpu_reset,
    input  logic            user_button,
    input  logic            step_button,
    input  logic [NREQ-1:0] pause_request,
    input  logic [2:0]      options,
    input  logic            OSD_STATUS,
    pause_ctrl_if.slave     video,
    output logic            pause_cpu,
    output logic [DLW-1:0]  dim_level,
    output logic [1:0]      state_dbg
);

    logic [1:0] state_q, state_d;
    logic       toggle_q, toggle_d;
    logic       pause_cpu_q, pause_cpu_d;
    logic       user_q, step_q, vblank_q;

    logic user_rise, step_rise, vblank_rise, want, dim_active;

    always_comb begin
        user_rise   = user_button & ~user_q;
        step_rise   = step_button & ~step_q;
        vblank_rise = video.vblank & ~vblank_q;

        toggle_d = cpu_reset ? 1'b0 : (toggle_q ^ user_rise);
        want     = ~cpu_reset & ((|pause_request) | toggle_q |
                                 (OSD_STATUS & options[OPT_OSD]));

        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (want)
                    state_d = (!options[OPT_ALIGN] || vblank_rise) ? ST_PAUSED : ST_PEND;
            end
            ST_PEND: begin
                if (!want)
                    state_d = ST_RUN;
                else if (vblank_rise)
                    state_d = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (!want)
                    state_d = ST_RUN;
                else if (step_rise)
                    state_d = ST_STEP;
            end
            default: begin
                // A step frame always runs to the next vblank unless pausing is dropped.
                if (vblank_rise)
                    state_d = want ? ST_PAUSED : ST_RUN;
                else if (!want)
                    state_d = ST_RUN;
            end
        endcase
        if (cpu_reset)
            state_d = ST_RUN;

        pause_cpu_d = (state_d == ST_PAUSED);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            toggle_q    <= 1'b0;
            pause_cpu_q <= 1'b0;
            user_q      <= 1'b0;
            step_q      <= 1'b0;
            vblank_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            toggle_q    <= toggle_d;
            pause_cpu_q <= pause_cpu_d;
            user_q      <= user_button;
            step_q      <= step_button;
            vblank_q    <= video.vblank;
        end
    end

    // A soft reset clears the dim in the same cycle it drops the pause.
    assign dim_active = (state_q == ST_PAUSED) & options[OPT_DIM] & ~cpu_reset;

    pause_dimmer #(
        .RW          (RW),
        .GW          (GW),
        .BW          (BW),
        .DIM_CYCLES  (DIM_CYCLES),
        .FADE_CYCLES (FADE_CYCLES),
        .MAX_DIM     (MAX_DIM),
        .DLW         (DLW)
    ) u_dimmer (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .active    (dim_active),
        .r         (video.r),
        .g         (video.g),
        .b         (video.b),
        .dim_level (dim_level),
        .rgb_out   (video.rgb_out)
    );

    assign pause_cpu = pause_cpu_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pause_ctrl.sv
// Bench for pause_ctrl: directed scenarios with literal expectations, then
// random stimulus checked every cycle against a behavioural model.
module tb_pause_ctrl;

    localparam int DIM  = 20;
    localparam int FADE = 5;
    localparam int MAXD = 3;

    localparam int S_RUN    = 0;
    localparam int S_PEND   = 1;
    localparam int S_PAUSED = 2;
    localparam int S_STEP   = 3;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpu_reset = 1'b0;
    logic       user_button = 1'b0;
    logic       step_button = 1'b0;
    logic [3:0] pause_request = 4'b0;
    logic [2:0] options = 3'b0;
    logic       OSD_STATUS = 1'b0;
    logic       pause_cpu;
    logic [1:0] dim_level;
    logic [1:0] state_dbg;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    pause_ctrl_if #(.RW(8), .GW(8), .BW(8)) vif ();

    pause_ctrl #(
        .RW(8), .GW(8), .BW(8), .CLKSPD(12), .NREQ(4),
        .DIM_CYCLES(DIM), .FADE_CYCLES(FADE), .MAX_DIM(MAXD)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .cpu_reset     (cpu_reset),
        .user_button   (user_button),
        .step_button   (step_button),
        .pause_request (pause_request),
        .options       (options),
        .OSD_STATUS    (OSD_STATUS),
        .video         (vif.slave),
        .pause_cpu     (pause_cpu),
        .dim_level     (dim_level),
        .state_dbg     (state_dbg)
    );

    always #5 clk_sys = ~clk_sys;

    // Behavioural model: state per the transition rules, dim as a function of
    // how many consecutive cycles the pause has been dim-eligible.
    int m_state = S_RUN;
    bit m_toggle = 1'b0;
    bit m_pause = 1'b0;
    int m_active_n = 0;
    bit m_user_prev = 1'b0, m_step_prev = 1'b0, m_vb_prev = 1'b0;

    function automatic int lvl_of(input int n);
        int l;
        if (n < DIM) return 0;
        l = 1 + (n - DIM) / FADE;
        return (l > MAXD) ? MAXD : l;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            m_state = S_RUN; m_toggle = 0; m_pause = 0; m_active_n = 0;
            m_user_prev = 0; m_step_prev = 0; m_vb_prev = 0;
        end else begin
            bit u_rise, s_rise, v_rise, want, dim_ok;
            int nxt;
            u_rise = user_button && !m_user_prev;
            s_rise = step_button && !m_step_prev;
            v_rise = vif.vblank && !m_vb_prev;
            want = !cpu_reset && ((pause_request != 0) || m_toggle || (OSD_STATUS && options[0]));
            dim_ok = (m_state == S_PAUSED) && options[1] && !cpu_reset;
            nxt = m_state;
            if (cpu_reset) nxt = S_RUN;
            else if (m_state == S_RUN) begin
                if (want) nxt = (!options[2] || v_rise) ? S_PAUSED : S_PEND;
            end else if (m_state == S_PEND) begin
                if (!want) nxt = S_RUN; else if (v_rise) nxt = S_PAUSED;
            end else if (m_state == S_PAUSED) begin
                if (!want) nxt = S_RUN; else if (s_rise) nxt = S_STEP;
            end else begin
                if (v_rise) nxt = want ? S_PAUSED : S_RUN;
                else if (!want) nxt = S_RUN;
            end
            m_active_n = dim_ok ? m_active_n + 1 : 0;
            m_toggle = cpu_reset ? 1'b0 : (m_toggle ^ u_rise);
            m_pause = (nxt == S_PAUSED);
            m_state = nxt;
            m_user_prev = user_button;
            m_step_prev = step_button;
            m_vb_prev = vif.vblank;
        end
    end

    always @(posedge clk_sys) begin
        #1;
        if (reset_n && check_en) begin
            int l;
            l = lvl_of(m_active_n);
            checkOutput("model_state", {30'b0, state_dbg}, m_state);
            checkOutput("model_pause", {31'b0, pause_cpu}, {31'b0, m_pause});
            checkOutput("model_dim", {30'b0, dim_level}, l);
            checkOutput("model_rgb", {8'b0, vif.rgb_out},
                        {8'b0, vif.r >> l, vif.g >> l, vif.b >> l});
        end
    end

    task automatic applyStimulus(input logic ub, input logic sb, input logic vb, input int hold);
        user_button = ub;
        step_button = sb;
        vif.vblank = vb;
        repeat (hold) @(negedge clk_sys);
    endtask

    task automatic checkState(input string name, input int st, input logic pc);
        checkOutput({name, "_state"}, {30'b0, state_dbg}, st);
        checkOutput({name, "_pause"}, {31'b0, pause_cpu}, {31'b0, pc});
    endtask

    initial begin
        int vb_cnt;
        vif.r = 8'hF0; vif.g = 8'hF0; vif.b = 8'hF0; vif.vblank = 1'b0;
        #12;
        checkState("reset", S_RUN, 1'b0);
        checkOutput("reset_dim", {30'b0, dim_level}, 0);
        checkOutput("reset_rgb", {8'b0, vif.rgb_out}, 32'hF0F0F0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        check_en = 1'b1;
        @(negedge clk_sys);

        // Immediate pause and unpause via the toggle.
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1_not_yet", {31'b0, pause_cpu}, 0);
        applyStimulus(0, 0, 0, 1);
        checkState("t1_paused", S_PAUSED, 1'b1);
        applyStimulus(1, 0, 0, 1);
        checkState("t1_still", S_PAUSED, 1'b1);
        applyStimulus(0, 0, 0, 1);
        checkState("t1_run", S_RUN, 1'b0);

        // Pause entry aligned to vblank.
        options = 3'b100;
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkState("t2_pend", S_PEND, 1'b0);
        applyStimulus(0, 0, 0, 5);
        checkState("t2_pend_late", S_PEND, 1'b0);
        applyStimulus(0, 0, 1, 1);
        checkState("t2_paused", S_PAUSED, 1'b1);

        // Frame step releases the CPU until the next vblank rise.
        applyStimulus(0, 1, 1, 1);
        checkState("t3_step", S_STEP, 1'b0);
        applyStimulus(0, 0, 0, 3);
        checkState("t3_step_hold", S_STEP, 1'b0);
        applyStimulus(0, 0, 1, 1);
        checkState("t3_repaused", S_PAUSED, 1'b1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkState("t3_unpaused", S_RUN, 1'b0);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 0, 2);
        checkState("t3_step_in_run", S_RUN, 1'b0);

        // Dim fade staircase.
        options = 3'b010;
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkState("t4_paused", S_PAUSED, 1'b1);
        applyStimulus(0, 0, 0, 19);
        checkOutput("t4_undimmed", {8'b0, vif.rgb_out}, 32'hF0F0F0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t4_dim1", {8'b0, vif.rgb_out}, 32'h787878);
        applyStimulus(0, 0, 0, 5);
        checkOutput("t4_dim2", {8'b0, vif.rgb_out}, 32'h3C3C3C);
        applyStimulus(0, 0, 0, 5);
        checkOutput("t4_dim3", {8'b0, vif.rgb_out}, 32'h1E1E1E);
        applyStimulus(0, 0, 0, 8);
        checkOutput("t4_sat_rgb", {8'b0, vif.rgb_out}, 32'h1E1E1E);
        checkOutput("t4_sat_lvl", {30'b0, dim_level}, 3);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 2);
        checkOutput("t4_undim", {8'b0, vif.rgb_out}, 32'hF0F0F0);

        // Request bus and OSD sources.
        options = 3'b000;
        pause_request = 4'b0100;
        applyStimulus(0, 0, 0, 1);
        checkState("t5_req", S_PAUSED, 1'b1);
        pause_request = 4'b0000;
        applyStimulus(0, 0, 0, 1);
        checkState("t5_req_drop", S_RUN, 1'b0);
        OSD_STATUS = 1'b1;
        applyStimulus(0, 0, 0, 2);
        checkState("t5_osd_off", S_RUN, 1'b0);
        options = 3'b001;
        applyStimulus(0, 0, 0, 2);
        checkState("t5_osd_on", S_PAUSED, 1'b1);
        OSD_STATUS = 1'b0;
        options = 3'b000;
        applyStimulus(0, 0, 0, 1);
        checkState("t5_osd_drop", S_RUN, 1'b0);

        // Soft reset cancels a dimmed toggle pause and beats a same-cycle press.
        options = 3'b010;
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 24);
        checkOutput("t6_dim_before", {30'b0, dim_level}, 1);
        cpu_reset = 1'b1;
        applyStimulus(0, 0, 0, 1);
        checkState("t6_cpu_reset", S_RUN, 1'b0);
        checkOutput("t6_cpu_reset_dim", {30'b0, dim_level}, 0);
        cpu_reset = 1'b0;
        applyStimulus(0, 0, 0, 3);
        checkState("t6_toggle_cleared", S_RUN, 1'b0);
        cpu_reset = 1'b1;
        applyStimulus(1, 0, 0, 1);
        cpu_reset = 1'b0;
        applyStimulus(0, 0, 0, 3);
        checkState("t6_press_lost", S_RUN, 1'b0);

        // Asynchronous hard reset in the middle of a fade.
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 31);
        checkOutput("t6_dim_full", {30'b0, dim_level}, 3);
        @(posedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        checkState("t6_hard_reset", S_RUN, 1'b0);
        checkOutput("t6_hard_dim", {30'b0, dim_level}, 0);
        checkOutput("t6_hard_rgb", {8'b0, vif.rgb_out}, 32'hF0F0F0);
        @(negedge clk_sys);
        reset_n = 1'b1;

        // Random traffic against the model.
        vb_cnt = 0;
        repeat (3000) begin
            @(negedge clk_sys);
            vb_cnt++;
            user_button = ($urandom_range(0, 79) == 0);
            step_button = ($urandom_range(0, 19) == 0);
            vif.vblank  = ((vb_cnt % 13) >= 10);
            cpu_reset   = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 59) == 0)
                pause_request = $urandom_range(0, 1) ? 4'b0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0)
                options = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0)
                OSD_STATUS = ~OSD_STATUS;
            vif.r = 8'($urandom);
            vif.g = 8'($urandom);
            vif.b = 8'($urandom);
        end
        @(negedge clk_sys);
        check_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pause_ctrl.md
Name: pause_ctrl

Overview:
Second-generation pause controller for arcade cores. It merges several pause sources: user toggle, OSD, and an NREQ-wide request bus from hiscore, debug and other blocks. Optionally it aligns pause entry to vertical blank and supports single-frame stepping while paused. While paused it applies a multi-level timed video dim to the RGB stream. It sits between the core's CPU clock-enable logic and the arcade_video input.

Parameters:
RW, 8, red channel width
GW, 8, green channel width
BW, 8, blue channel width
CLKSPD, 12, clk_sys frequency in MHz
NREQ, 4, number of pause_request lines
DIM_CYCLES, CLKSPD*10_000_000, paused cycles before first dim step (10 s)
FADE_CYCLES, CLKSPD*1_000_000, cycles between later dim steps (1 s)
MAX_DIM, 3, maximum right-shift applied to each channel; must be less than or equal to min(RW,GW,BW)

Ports:
clk_sys  in  1  core system clock
reset_n  in  1  asynchronous active-low reset
cpu_reset  in  1  core soft reset, active-high, synchronous; cancels pause
user_button  in  1  pause toggle button, active-high
step_button  in  1  frame-step button, active-high
pause_request  in  NREQ  external pause requests, OR-reduced, active-high
options  in  3  [0] pause while OSD open, [1] dim enable, [2] align pause entry to vblank
OSD_STATUS  in  1  OSD open
vblank  in  1  core vertical blank, clk_sys synchronous
r  in  RW  red in
g  in  GW  green in
b  in  BW  blue in
pause_cpu  out  1  registered CPU halt, active-high
dim_level  out  clog2(MAX_DIM+1)  current dim shift
state_dbg  out  2  FSM state encoding
rgb_out  out  RW+GW+BW  {r>>dim_level, g>>dim_level, b>>dim_level}

Behaviour:
- Reset values (reset_n=0, asynchronous): state RUN, pause_cpu 0, toggle 0, dim_level 0, timers 0, edge-detect registers 0.
- Edge detects: registered previous values of user_button, step_button and vblank; rising edge = current & !previous.
- Toggle: flips on user_button rise. cpu_reset forces toggle to 0 and wins over a same-cycle rise.
- want = |pause_request | toggle | (OSD_STATUS & options[0]). want is forced to 0 while cpu_reset=1.
- FSM (state_dbg: RUN=0, PEND=1, PAUSED=2, STEP=3):
  - RUN: if want and !options[2] → PAUSED. If want, options[2] and vblank rise this cycle → PAUSED. If want and options[2] otherwise → PEND.
  - PEND: !want → RUN. Vblank rise → PAUSED.
  - PAUSED: !want → RUN. Step rise → STEP.
  - STEP: on vblank rise → PAUSED if want, else RUN. !want before the edge → RUN.
  - cpu_reset in any state → RUN next cycle.
- pause_cpu is registered and equals (next_state==PAUSED), so it is high the cycle after the transition decision. It is 0 in RUN, PEND and STEP. STEP releases the CPU for exactly one vblank-to-vblank frame.
- Dim timer:
  - Counts only in PAUSED with options[1]=1.
  - Reaching DIM_CYCLES sets dim_level=1 and restarts counting toward FADE_CYCLES.
  - Each further FADE_CYCLES increments dim_level, saturating at MAX_DIM; the timer holds at saturation.
  - Leaving PAUSED, or options[1]=0, clears the timer and dim_level in the next cycle.
- Timer width is clog2(max(DIM_CYCLES,FADE_CYCLES)+1). No wrap is permitted.
- rgb_out is combinational from the inputs and registered dim_level, with zero added pixel latency. Vacated MSBs are filled with zeros.

Decomposition:
- Shared package pause_pkg holds:
  - state encodings (RUN/PEND/PAUSED/STEP)
  - option bit index constants OPT_OSD=0, OPT_DIM=1, OPT_ALIGN=2
  - a dim-width function
- Natural sub-module: pause_dimmer, containing the dim timer, dim_level saturation and the per-channel shifter. It takes active=(state==PAUSED & options[1]).

Test Plan:
(Test parameters throughout: DIM_CYCLES=20, FADE_CYCLES=5, MAX_DIM=3, RW=GW=BW=8.)
1. Immediate pause: options=3'b000, pulse user_button 1 cycle → pause_cpu=1 two cycles after the press (edge plus register). A second pulse → pause_cpu=0. state_dbg 0→2→0.
2. Aligned pause: options[2]=1, press user_button, vblank rises 7 cycles later → state PEND for 7 cycles with pause_cpu=0, then PAUSED and pause_cpu=1 one cycle after the vblank rise.
3. Frame step: while PAUSED, pulse step_button → pause_cpu=0 until the next vblank rise, then 1 again; state_dbg 2→3→2. A step press in RUN has no effect.
4. Dim fade: options[1]=1, paused, r=g=b=8'hF0 → rgb_out unchanged for 20 cycles, then 8'h78 each; 8'h3C after 5 more cycles; 8'h1E after 5 more; holds at 8'h1E (dim_level=3). Unpausing gives 8'hF0 the next cycle.
5. Request and OSD sources: pause_request=4'b0100 → paused; drop it → RUN. OSD_STATUS=1 with options[0]=0 → stays RUN; with options[0]=1 → paused.
6. Reset cases:
   - cpu_reset asserted while toggle-paused, or in the same cycle as a user_button rise → pause_cpu=0 next cycle, toggle=0, dim_level=0.
   - reset_n low mid-fade → all outputs 0 and rgb_out unshifted, asynchronously.
